// File: rtl/nco_bank.sv
// nco_bank: multi-channel NCO bank with shadow/active configuration registers.
// Per channel: carrier phase accumulator driving a full-wave sine LUT, and a
// code phase accumulator (with phase offset) driving a square-wave code clock
// plus a one-cycle rising-edge pulse. Output latency is 2 cycles.
// Optional feature: define NCO_BANK_DITHER_EN to add LFSR phase dither to the
// carrier LUT address (carrier path only, latency unchanged).
module nco_bank #(
    parameter int CH     = 8,
    parameter int ACC_W  = 28,
    parameter int DAC_W  = 14,
    parameter int LUT_AW = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr,
    input  logic [3:0]            cfg_ch,
    input  logic [1:0]            cfg_sel,
    input  logic [ACC_W-1:0]      cfg_data,
    input  logic                  upd,
    input  logic                  upd_clr,
    output logic [CH*DAC_W-1:0]   carrier,
    output logic [CH-1:0]         code_clk,
    output logic [CH-1:0]         code_edge
);

    typedef logic [ACC_W-1:0] word_t;

    localparam int  LUT_N = 2 ** LUT_AW;
    localparam real AMP   = real'((2 ** (DAC_W - 1)) - 1);
    localparam real PI    = 3.14159265358979323846;

    word_t r_sh_fc [CH];
    word_t r_sh_fm [CH];
    word_t r_sh_off[CH];
    word_t r_fc    [CH];
    word_t r_fm    [CH];
    word_t r_off   [CH];
    word_t r_acc_c [CH];
    word_t r_acc_m [CH];

    logic [LUT_AW-1:0]        r_addr[CH];
    logic [CH-1:0]            r_clk_s1;
    logic signed [DAC_W-1:0]  r_car[CH];
    logic [CH-1:0]            r_code_clk;
    logic [CH-1:0]            r_code_edge;
    logic [1:0]               r_vld;

    word_t                    w_cph[CH];
    word_t                    w_pm [CH];
    logic signed [DAC_W-1:0]  w_lut[LUT_N];

    // Sine table built at elaboration: round-half-away-from-zero of AMP*sin
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        localparam real X = AMP * $sin(2.0 * PI * real'(k) / real'(LUT_N));
        localparam int  V = (X >= 0.0) ? $rtoi(X + 0.5) : -$rtoi(0.5 - X);
        assign w_lut[k] = DAC_W'(V);
    end

`ifdef NCO_BANK_DITHER_EN
    localparam int DW = ACC_W - LUT_AW;

    logic [15:0] r_lfsr;
    word_t       w_dith;

    assign w_dith = word_t'(r_lfsr) & word_t'((64'd1 << DW) - 64'd1);

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= 16'd1;
        else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
`endif

    // Carrier LUT phase (optionally dithered) and code phase with offset
    always_comb begin
        for (int unsigned n = 0; n < CH; n++) begin
`ifdef NCO_BANK_DITHER_EN
            w_cph[n] = r_acc_c[n] + w_dith;
`else
            w_cph[n] = r_acc_c[n];
`endif
            w_pm[n]  = r_acc_m[n] + r_off[n];
        end
    end

    // Shadow writes, shadow->active transfer and phase accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned n = 0; n < CH; n++) begin
                r_sh_fc[n]  <= '0;
                r_sh_fm[n]  <= '0;
                r_sh_off[n] <= '0;
                r_fc[n]     <= '0;
                r_fm[n]     <= '0;
                r_off[n]    <= '0;
                r_acc_c[n]  <= '0;
                r_acc_m[n]  <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < CH; n++) begin
                // Channels >= CH never match, so such writes fall away
                if (cfg_wr && cfg_ch == 4'(n)) begin
                    case (cfg_sel)
                        2'd0:    r_sh_fc[n]  <= cfg_data;
                        2'd1:    r_sh_fm[n]  <= cfg_data;
                        2'd2:    r_sh_off[n] <= cfg_data;
                        default: ;
                    endcase
                end
                // Non-blocking reads give the pre-write shadow on a coincident write
                if (upd) begin
                    r_fc[n]  <= r_sh_fc[n];
                    r_fm[n]  <= r_sh_fm[n];
                    r_off[n] <= r_sh_off[n];
                end
                if (upd && upd_clr) begin
                    r_acc_c[n] <= '0;
                    r_acc_m[n] <= '0;
                end else begin
                    r_acc_c[n] <= r_acc_c[n] + r_fc[n];
                    r_acc_m[n] <= r_acc_m[n] + r_fm[n];
                end
            end
        end
    end

    // Two-stage output pipeline: LUT address / code level, then sample / edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1    <= '0;
            r_code_clk  <= '0;
            r_code_edge <= '0;
            r_vld       <= '0;
            for (int unsigned n = 0; n < CH; n++) begin
                r_addr[n] <= '0;
                r_car[n]  <= '0;
            end
        end else begin
            r_vld       <= {r_vld[0], 1'b1};
            r_code_clk  <= r_clk_s1;
            // r_vld masks the 0->1 transition of the pipeline refilling after reset
            r_code_edge <= r_clk_s1 & ~r_code_clk & {CH{r_vld[1]}};
            for (int unsigned n = 0; n < CH; n++) begin
                r_addr[n]   <= w_cph[n][ACC_W-1 -: LUT_AW];
                r_clk_s1[n] <= ~w_pm[n][ACC_W-1];
                r_car[n]    <= w_lut[r_addr[n]];
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_out
        assign carrier[g*DAC_W +: DAC_W] = r_car[g];
    end

    assign code_clk  = r_code_clk;
    assign code_edge = r_code_edge;

endmodule

// File: tb/tb_nco_bank.sv
// tb_nco_bank: directed self-checking bench for nco_bank (default build,
// dither disabled, CH=8, ACC_W=28, DAC_W=14, LUT_AW=10).
module tb_nco_bank;

    localparam int CH     = 8;
    localparam int ACC_W  = 28;
    localparam int DAC_W  = 14;
    localparam int LUT_AW = 10;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cfg_wr = 1'b0;
    logic [3:0]            cfg_ch = '0;
    logic [1:0]            cfg_sel = '0;
    logic [ACC_W-1:0]      cfg_data = '0;
    logic                  upd = 1'b0;
    logic                  upd_clr = 1'b0;
    logic [CH*DAC_W-1:0]   carrier;
    logic [CH-1:0]         code_clk;
    logic [CH-1:0]         code_edge;

    int n_tests = 0;
    int n_fail  = 0;

    int pat[4] = '{0, 8191, 0, -8191};
    int fine[4] = '{0, 201, 402, 603};

    nco_bank #(
        .CH     (CH),
        .ACC_W  (ACC_W),
        .DAC_W  (DAC_W),
        .LUT_AW (LUT_AW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .upd       (upd),
        .upd_clr   (upd_clr),
        .carrier   (carrier),
        .code_clk  (code_clk),
        .code_edge (code_edge)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int car(input int n);
        return int'($signed(carrier[n*DAC_W +: DAC_W]));
    endfunction

    function automatic logic exp_clk(input int j);
        return (j < 0) ? 1'b1 : ((j % 16) < 8);
    endfunction

    task automatic do_reset();
        cfg_wr = 0; upd = 0; upd_clr = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    task automatic wr(input int ch, input int sel, input logic [ACC_W-1:0] d);
        cfg_wr = 1; cfg_ch = 4'(ch); cfg_sel = 2'(sel); cfg_data = d;
        tick();
        cfg_wr = 0;
    endtask

    task automatic do_upd(input logic clr);
        upd = 1; upd_clr = clr;
        tick();
        upd = 0; upd_clr = 0;
    endtask

    initial begin
        // Reset state and post-reset code_edge suppression
        tick(); tick();
        check("rst_carrier", 128'(carrier), '0);
        check("rst_code_clk", 128'(code_clk), '0);
        check("rst_code_edge", 128'(code_edge), '0);
        rst = 0;
        tick();
        check("rel1_code_clk", 128'(code_clk), '0);
        check("rel1_code_edge", 128'(code_edge), '0);
        tick();
        check("rel2_code_clk", 128'(code_clk), 128'(8'hFF));
        check("rel2_code_edge", 128'(code_edge), '0);
        tick();
        check("rel3_code_edge", 128'(code_edge), '0);

        // Code clock period 16 on ch0
        do_reset();
        wr(0, 1, 28'(1 << 24));
        do_upd(1'b0);
        for (int t = 1; t <= 40; t++) begin
            int j;
            j = t - 2;
            tick();
            check($sformatf("cclk0_t%0d", t), 128'(code_clk[0]), 128'(exp_clk(j)));
            check($sformatf("cedge0_t%0d", t), 128'(code_edge[0]), 128'(j > 0 && j % 16 == 0));
        end

        // Quarter-rate carrier on ch3
        do_reset();
        wr(3, 0, 28'(1 << 26));
        do_upd(1'b1);
        for (int t = 1; t <= 13; t++) begin
            tick();
            check($sformatf("car3_t%0d", t), 128'(car(3)), 128'((t >= 2) ? pat[(t - 2) % 4] : 0));
            check($sformatf("car0_t%0d", t), 128'(car(0)), '0);
        end

        // Phase offset of half a cycle inverts ch1 relative to ch0
        do_reset();
        wr(0, 1, 28'(1 << 24));
        wr(1, 1, 28'(1 << 24));
        wr(1, 2, 28'(1 << 27));
        do_upd(1'b1);
        for (int t = 1; t <= 40; t++) begin
            int j;
            logic c;
            j = t - 2;
            c = exp_clk(j);
            tick();
            if (t >= 2) begin
                check($sformatf("inv_clk_t%0d", t), 128'(code_clk[1:0]), 128'({~c, c}));
                check($sformatf("inv_edge_t%0d", t), 128'(code_edge[1:0]),
                      128'({(j % 16 == 8), (j > 0 && j % 16 == 0)}));
            end
        end

        // Write coincident with upd only takes effect at the following upd
        do_reset();
        wr(3, 0, 28'(1 << 26));
        do_upd(1'b1);
        for (int t = 1; t <= 12; t++) begin
            if (t == 5) begin
                cfg_wr = 1; cfg_ch = 4'd3; cfg_sel = 2'd0; cfg_data = 28'(1 << 20); upd = 1;
            end
            tick();
            cfg_wr = 0; upd = 0;
            check($sformatf("coinc_t%0d", t), 128'(car(3)), 128'((t >= 2) ? pat[(t - 2) % 4] : 0));
        end
        do_upd(1'b1);
        tick();
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("newf_j%0d", j), 128'(car(3)), 128'(fine[j]));
        end

        // Mid-run reset with a lost write/update in the reset cycle
        do_reset();
        wr(0, 1, 28'(1 << 24));
        wr(3, 0, 28'(1 << 26));
        do_upd(1'b1);
        for (int t = 0; t < 21; t++) tick();
        rst = 1; cfg_wr = 1; cfg_ch = 4'd3; cfg_sel = 2'd0; cfg_data = 28'(1 << 26); upd = 1;
        tick();
        rst = 0; cfg_wr = 0; upd = 0;
        check("mrst_carrier", 128'(carrier), '0);
        check("mrst_code_clk", 128'(code_clk), '0);
        check("mrst_code_edge", 128'(code_edge), '0);
        tick();
        check("mrst1_code_clk", 128'(code_clk), '0);
        check("mrst1_code_edge", 128'(code_edge), '0);
        tick();
        check("mrst2_carrier", 128'(carrier), '0);
        check("mrst2_code_clk", 128'(code_clk), 128'(8'hFF));
        check("mrst2_code_edge", 128'(code_edge), '0);
        do_upd(1'b0);
        for (int t = 1; t <= 20; t++) begin
            tick();
            check($sformatf("post_car_t%0d", t), 128'(carrier), '0);
            check($sformatf("post_clk_t%0d", t), 128'(code_clk), 128'(8'hFF));
            check($sformatf("post_edge_t%0d", t), 128'(code_edge), '0);
        end

        // Out-of-range channel and reserved selector are ignored
        do_reset();
        wr(12, 0, 28'(1 << 26));
        wr(3, 3, 28'(1 << 26));
        wr(12, 1, 28'(1 << 24));
        do_upd(1'b1);
        for (int t = 1; t <= 20; t++) begin
            tick();
            check($sformatf("ign_car_t%0d", t), 128'(carrier), '0);
            check($sformatf("ign_clk_t%0d", t), 128'(code_clk), 128'(8'hFF));
            check($sformatf("ign_edge_t%0d", t), 128'(code_edge), '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
